// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: op codes, bus widths,
// FSM states and a sign-magnitude helper.
package mdu_ctrl_pkg;

  localparam int MDU_OP_WD        = 3;
  localparam int ES_TO_MDU_BUS_WD = 67;
  localparam int DIV_CYCLES       = 32;

  typedef enum logic [MDU_OP_WD-1:0] {
    MDU_OP_MULT  = 3'd0,
    MDU_OP_MULTU = 3'd1,
    MDU_OP_DIV   = 3'd2,
    MDU_OP_DIVU  = 3'd3,
    MDU_OP_MTHI  = 3'd4,
    MDU_OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } mdu_state_e;

  typedef struct packed {
    logic [MDU_OP_WD-1:0] op;
    logic [31:0]          src1;
    logic [31:0]          src2;
  } es_to_mdu_t;

  function automatic logic [31:0] mag32(
    input logic [31:0] v,
    input logic        neg
  );
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// One-bit-per-cycle restoring divider datapath.
// quotient/remainder show the result of the current step.
module mdu_ctrl_div_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dsr_q;
  logic [32:0] part;
  logic [32:0] diff;

  // compare rather than test the borrow so a zero divisor
  // always yields a 1 quotient bit
  always_comb begin
    part = {rem_q, quo_q[31]};
    diff = part - {1'b0, dsr_q};
    if (part >= {1'b0, dsr_q}) begin
      remainder = diff[31:0];
      quotient  = {quo_q[30:0], 1'b1};
    end else begin
      remainder = part[31:0];
      quotient  = {quo_q[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (step) begin
      rem_q <= remainder;
      quo_q <= quotient;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer owning HI/LO, beside
// the execute stage.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state;
  logic [4:0]  cnt;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_sgn;
  logic        neg_q;
  logic        neg_r;
  logic        accept;
  logic        is_mul;
  logic        is_div;
  logic        is_mthi;
  logic        is_mtlo;
  logic        op_sgn;
  logic        s1_neg;
  logic        s2_neg;
  logic        div_load;
  logic        div_step;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] div_q;
  logic [31:0] div_r;

  assign req_ready = (state == S_IDLE) && !flush;
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    op_sgn  = 1'b0;
    case (req_op)
      MDU_OP_MULT:  begin is_mul = 1'b1; op_sgn = 1'b1; end
      MDU_OP_MULTU: is_mul = 1'b1;
      MDU_OP_DIV:   begin is_div = 1'b1; op_sgn = 1'b1; end
      MDU_OP_DIVU:  is_div = 1'b1;
      MDU_OP_MTHI:  is_mthi = 1'b1;
      MDU_OP_MTLO:  is_mtlo = 1'b1;
      default: ;
    endcase
  end

  assign s1_neg   = op_sgn && req_src1[31];
  assign s2_neg   = op_sgn && req_src2[31];
  assign div_load = accept && is_div;
  assign div_step = (state == S_DIV) && !flush;

  assign ext_a = {{32{mul_sgn & mul_a[31]}}, mul_a};
  assign ext_b = {{32{mul_sgn & mul_b[31]}}, mul_b};
  assign prod  = ext_a * ext_b;

  mdu_ctrl_div_iter u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag32(req_src1, s1_neg)),
    .divisor  (mag32(req_src2, s2_neg)),
    .quotient (div_q),
    .remainder(div_r)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_sgn <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_mthi: hi <= req_src1;
              is_mtlo: lo <= req_src1;
              is_mul: begin
                mul_a   <= req_src1;
                mul_b   <= req_src2;
                mul_sgn <= op_sgn;
                cnt     <= 5'(MUL_CYCLES - 1);
                state   <= S_MUL;
              end
              is_div: begin
                // divide-by-zero keeps the all-ones quotient
                neg_q <= (s1_neg ^ s2_neg) && (req_src2 != '0);
                neg_r <= s1_neg;
                cnt   <= 5'(DIV_CYCLES - 1);
                state <= S_DIV;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            {hi, lo} <= prod;
            done     <= 1'b1;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            lo    <= mag32(div_q, neg_q);
            hi    <= mag32(div_r, neg_r);
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer and owner of the shared multiply/divide resource and the HI/LO architectural registers.
- Sits beside the execute stage. The execute stage hands it MULT/MULTU/DIV/DIVU/MTHI/MTLO operands with a valid/ready handshake.
- Exposes busy so the decode-stage interlock can stall any HI/LO consumer (MFHI/MFLO, or another mult/div) until the result lands.
- Contains the cycle counter, FSM, sign handling and one iterative restoring divider.

Parameters:
- MUL_CYCLES, 2, cycles spent in MUL before HI/LO update; legal range 1..4.
- DIV_CYCLES, 32, divider iterations; fixed at 32 for 32-bit operands, not user-overridable.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  execute stage presents an MDU operation.
- req_ready  output  1  MDU accepts an operation this cycle.
- req_op  input  3  `MDU_OP_MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6 and 7 are ignored.
- req_src1  input  32  rs value (dividend / multiplicand / MTHI-MTLO data).
- req_src2  input  32  rt value (divisor / multiplier).
- flush  input  1  cancels any in-flight operation (exception/eret).
- busy  output  1  a MULT/DIV operation is in flight.
- done  output  1  one-cycle pulse: HI/LO were updated by a MULT/DIV on the previous edge.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, req_ready=1, counter=0.
  - Any in-flight operation is discarded.
- FSM states: IDLE, MUL, DIV.
- Derived outputs: req_ready = (state==IDLE) && !flush; busy = (state!=IDLE).
- Accept: an operation is accepted on an edge where req_valid && req_ready, with req_op in 0..5.
- MTHI/MTLO:
  - hi (or lo) <= req_src1 on the accepting edge.
  - State stays IDLE; done stays 0.
  - Back-to-back MTHI/MTLO are accepted every cycle.
- MULT/MULTU:
  - On accept, latch the operands; state -> MUL; counter <= MUL_CYCLES-1.
  - In MUL, the counter decrements each cycle. On the edge where counter==0: {hi,lo} <= 64-bit product (signed for MULT, unsigned for MULTU); state -> IDLE; done <= 1.
  - Accept-to-done latency = MUL_CYCLES+1 cycles. The done cycle already shows the new hi/lo.
- DIV/DIVU:
  - On accept, latch |src1| and |src2| (raw values for DIVU) and the sign flags; state -> DIV; counter <= 31.
  - Each DIV cycle performs one restoring shift-subtract step. After the counter==0 step, apply sign fix-up and write back on that same edge:
    - quotient negated if sign1^sign2, written to lo.
    - remainder negated if sign1, written to hi.
  - Then state -> IDLE; done <= 1.
  - busy is high for exactly 32 cycles; done pulses in cycle 33 after accept.
- Divide by zero (src2==0, any signedness): runs the full 32 cycles, then lo=0xFFFFFFFF and hi=raw src1.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This falls out of the magnitude path; no special case is needed.
- flush:
  - In MUL/DIV: state -> IDLE on the next edge; hi/lo unchanged; done stays 0.
  - In IDLE: req_ready is forced low, so a simultaneous request is dropped (flush wins).
  - flush on the final MUL/DIV edge also wins: no write-back.
- Requests while busy: req_ready=0; the execute stage must hold the request. Operands are never re-sampled after accept.
- done is cleared on every edge where it is not being set.

Decomposition:
- Shared header (mycpu.h):
  - `MDU_OP_* codes and `MDU_OP_WD=3.
  - An `ES_TO_MDU_BUS_WD bundle width (valid excluded; op+src1+src2 = 67).
- Sub-module div_iter:
  - Holds the 32-bit remainder/quotient shift registers and one-step restoring subtract.
  - Controls: load, step, and operands in; quotient/remainder out.
  - mdu_ctrl owns the FSM, counter, sign logic, multiplier and HI/LO.

Test Plan:
- Reset: assert reset mid-DIV (iteration 10), asynchronously -> busy=0, hi=lo=0, done=0 before the next edge; req_ready=1 after deassert.
- MULTU: 0xFFFFFFFF x 0xFFFFFFFF, MUL_CYCLES=2 -> done high 3 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 2 cycles.
- Signed DIV: -7 / 2 -> busy 32 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF, done pulse 1 cycle. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU by zero: 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678 after 32 cycles.
- Flush: flush at DIV iteration 10 -> busy=0 next cycle, hi/lo keep prior values, no done. Flush together with req_valid(MTLO) in IDLE -> lo unchanged.
- MTHI/MTLO: MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A on consecutive cycles -> hi and lo updated one edge each, busy never asserts. A MULT presented while busy is held off until req_ready=1.
